// File: rtl/fp_div_pkg.sv
// Shared types and constants for the fp_div binary32 divider.
package fp_div_pkg;
  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fclass_t;
endpackage

// File: rtl/fp_div_unpack.sv
// Combinational binary32 field splitter; subnormals are flushed to zero.
module fp_unpack
  import fp_div_pkg::*;
(
  input  logic [31:0]       x,
  output logic              sign,
  output logic [EXP_W-1:0]  expo,
  output logic [FRAC_W:0]   mant,
  output fclass_t           cls
);
  always_comb begin
    sign = x[31];
    expo = x[30:23];
    mant = (expo == '0) ? '0 : {1'b1, x[22:0]};
    if (expo == '0)
      cls = ZERO;
    else if (expo == '1)
      cls = (x[22:0] == '0) ? INF : NAN;
    else
      cls = NORMAL;
  end
endmodule

// File: rtl/fp_div.sv
// Multicycle restoring binary32 divider with valid/ready handshakes.
// FP_DIV_RNE_EN selects round-to-nearest-even; otherwise results truncate.
module fp_div
  import fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        dz
);
  state_t state, state_nx;

  logic sa, sb;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb;
  fclass_t ca, cb;

  fp_unpack u_unpack_a (.x(a), .sign(sa), .expo(ea), .mant(ma), .cls(ca));
  fp_unpack u_unpack_b (.x(b), .sign(sb), .expo(eb), .mant(mb), .cls(cb));

  logic        sign_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] mb_q;
  logic [25:0] quo, rem, diff, rem_nx;
  logic [4:0]  cnt;
  logic        accept, special, dz_spec, ge;
  logic [31:0] y_spec, y_norm;

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : DIV;
      DIV:     if (cnt == 5'd25) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Special operand results are resolved at acceptance and skip the datapath.
  always_comb begin
    special = (ca != NORMAL) || (cb != NORMAL);
    dz_spec = 1'b0;
    y_spec  = {sa ^ sb, 31'h0};
    if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF))
      y_spec = QNAN;
    else if (ca == INF)
      y_spec = POS_INF | {sa ^ sb, 31'h0};
    else if (cb == ZERO) begin
      y_spec  = POS_INF | {sa ^ sb, 31'h0};
      dz_spec = 1'b1;
    end
  end

  always_comb begin
    ge     = rem >= {2'b00, mb_q};
    diff   = rem - {2'b00, mb_q};
    rem_nx = (ge ? diff : rem) << 1;
  end

  logic signed [9:0] e0, e1, e2;
  logic [22:0] frac_raw, frac;
  logic        inc, carry;
`ifdef FP_DIV_RNE_EN
  logic guard, sticky;
`endif

  // quo[25] is the integer bit of ma/mb; the quotient lies in (0.5, 2).
  always_comb begin
    e0       = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    frac_raw = quo[25] ? quo[24:2] : quo[23:1];
    e1       = quo[25] ? e0 : e0 - 10'sd1;
`ifdef FP_DIV_RNE_EN
    guard  = quo[25] ? quo[1] : quo[0];
    sticky = (quo[25] & quo[0]) | (|rem);
    inc    = guard & (sticky | frac_raw[0]);
`else
    inc    = 1'b0;
`endif
    carry = inc & (&frac_raw);
    frac  = frac_raw + {22'h0, inc};
    e2    = carry ? e1 + 10'sd1 : e1;
    if (e2 >= 10'sd255)
      y_norm = POS_INF | {sign_q, 31'h0};
    else if (e2 <= 10'sd0)
      y_norm = {sign_q, 31'h0};
    else
      y_norm = {sign_q, e2[7:0], frac};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      y      <= '0;
      dz     <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      mb_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          sign_q <= sa ^ sb;
          ea_q   <= ea;
          eb_q   <= eb;
          mb_q   <= mb;
          rem    <= {2'b00, ma};
          quo    <= '0;
          cnt    <= '0;
          if (special) begin
            y  <= y_spec;
            dz <= dz_spec;
          end
        end
        DIV: begin
          quo <= {quo[24:0], ge};
          rem <= rem_nx;
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          y  <= y_norm;
          dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
